// File: rtl/scrambler_ctrl_mlane_if.sv
// Bundle of the scrambler controller's symbol input and control output
// signals. The master modport drives symbols in; the slave modport is the
// controller.
//
// Handshake: a symbol slice is taken when sym_valid=1 and back_pressure=0 on
// a rising clock edge. back_pressure=1 freezes all controller state and
// outputs (except advance, which drops to 0). Each taken slice appears on the
// *_o / control outputs exactly one cycle later, with sym_valid_o=1.
interface scrambler_ctrl_mlane_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SYM_CNT_W  = 4
);
  logic                        gen3_mode;
  logic                        sym_valid;
  logic                        back_pressure;
  logic [LANES-1:0]            sync_header;
  logic [LANES-1:0]            is_k;
  logic [LANES*DATA_WIDTH-1:0] sym_data;
  logic [LANES*DATA_WIDTH-1:0] sym_data_o;
  logic                        sym_valid_o;
  logic [SYM_CNT_W-1:0]        sym_count_o;
  logic [LANES-1:0]            lfsr_rst;
  logic [LANES-1:0]            scr_en;
  logic [LANES-1:0]            advance;
  logic [LANES*3-1:0]          lane_state_dbg;

  modport master (
    output gen3_mode, sym_valid, back_pressure, sync_header, is_k, sym_data,
    input  sym_data_o, sym_valid_o, sym_count_o, lfsr_rst, scr_en, advance,
           lane_state_dbg
  );

  modport slave (
    input  gen3_mode, sym_valid, back_pressure, sync_header, is_k, sym_data,
    output sym_data_o, sym_valid_o, sym_count_o, lfsr_rst, scr_en, advance,
           lane_state_dbg
  );
endinterface

// File: rtl/scrambler_ctrl_mlane.sv
// Multi-lane TX scrambler controller. Keeps a shared 128b/130b symbol counter
// and gen-mode latch, classifies each lane's block, and produces registered
// per-lane lfsr_rst / scr_en / advance aligned with the delayed symbol data.
// Optional macro SCR_TS_TAIL_SCRAMBLE_EN: when defined, TS symbols 14..15 are
// scrambled; otherwise they bypass the scrambler (LFSR still advances).
module scrambler_ctrl_mlane #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SYM_CNT_W  = 4
) (
  input logic                   CLK,
  input logic                   RST,
  scrambler_ctrl_mlane_if.slave bus
);
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DATA     = 3'd1;
  localparam logic [2:0] ST_TS       = 3'd2;
  localparam logic [2:0] ST_EIEOS    = 3'd3;
  localparam logic [2:0] ST_SKP      = 3'd4;
  localparam logic [2:0] ST_OS_OTHER = 3'd5;

  localparam logic [DATA_WIDTH-1:0] OS_TS1     = DATA_WIDTH'(8'h1E);
  localparam logic [DATA_WIDTH-1:0] OS_TS2     = DATA_WIDTH'(8'h2D);
  localparam logic [DATA_WIDTH-1:0] OS_EIEOS   = DATA_WIDTH'(8'h00);
  localparam logic [DATA_WIDTH-1:0] OS_SKP     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] EIE_EVEN   = DATA_WIDTH'(8'h00);
  localparam logic [DATA_WIDTH-1:0] EIE_ODD    = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] K_COM      = DATA_WIDTH'(8'hBC);
  localparam logic [DATA_WIDTH-1:0] K_SKP      = DATA_WIDTH'(8'h1C);
  localparam logic [DATA_WIDTH-1:0] D_TS1_ID   = DATA_WIDTH'(8'h4A);
  localparam logic [DATA_WIDTH-1:0] D_TS2_ID   = DATA_WIDTH'(8'h45);

  localparam logic [SYM_CNT_W-1:0] CNT_LAST = {SYM_CNT_W{1'b1}};
  localparam logic [SYM_CNT_W-1:0] CNT_TAIL = CNT_LAST - SYM_CNT_W'(1);

`ifdef SCR_TS_TAIL_SCRAMBLE_EN
  localparam logic TS_TAIL_SCR = 1'b1;
`else
  localparam logic TS_TAIL_SCR = 1'b0;
`endif

  logic                        accept;
  logic                        blk_start;
  logic                        last_sym;
  logic                        gen3_eff;
  logic                        gen3_q;
  logic [SYM_CNT_W-1:0]        cnt_q, cnt_d;
  logic [LANES-1:0][2:0]       state_q, state_d;
  logic [LANES-1:0]            eieos_ok_q, eieos_ok_d;
  logic [LANES-1:0]            ts_q, ts_d;
  logic [LANES-1:0]            com_q, com_d;
  logic [LANES-1:0]            rst_d, scr_d, adv_d;
  logic [LANES*DATA_WIDTH-1:0] data_o_q;
  logic                        valid_o_q;
  logic [SYM_CNT_W-1:0]        count_o_q;
  logic [LANES-1:0]            rst_o_q, scr_o_q, adv_o_q;
  logic [DATA_WIDTH-1:0]       lane_sym;
  logic [2:0]                  lane_cls;
  logic                        lane_ok;
  logic                        lane_ts;

  // Block classification and per-lane control decode for the current symbol.
  always_comb begin
    accept     = bus.sym_valid & ~bus.back_pressure;
    blk_start  = (cnt_q == '0);
    last_sym   = (cnt_q == CNT_LAST);
    // The mode only changes on a block boundary; mid-block it is the latch.
    gen3_eff   = blk_start ? bus.gen3_mode : gen3_q;
    cnt_d      = gen3_eff ? cnt_q + SYM_CNT_W'(1) : '0;
    state_d    = '0;
    eieos_ok_d = eieos_ok_q;
    ts_d       = '0;
    com_d      = '0;
    rst_d      = '0;
    scr_d      = '0;
    adv_d      = '0;
    lane_sym   = '0;
    lane_cls   = ST_IDLE;
    lane_ok    = 1'b0;
    lane_ts    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_sym = bus.sym_data[l*DATA_WIDTH +: DATA_WIDTH];
      if (gen3_eff) begin
        lane_cls = state_q[l];
        lane_ok  = eieos_ok_q[l];
        // Symbol 0 decides the block type and is itself handled under it.
        if (blk_start) begin
          lane_ok = 1'b1;
          if (!bus.sync_header[l])                          lane_cls = ST_DATA;
          else if (lane_sym == OS_TS1 || lane_sym == OS_TS2) lane_cls = ST_TS;
          else if (lane_sym == OS_EIEOS)                    lane_cls = ST_EIEOS;
          else if (lane_sym == OS_SKP)                      lane_cls = ST_SKP;
          else                                              lane_cls = ST_OS_OTHER;
        end
        case (lane_cls)
          ST_DATA: begin
            scr_d[l] = 1'b1;
            adv_d[l] = 1'b1;
          end
          ST_TS: begin
            adv_d[l] = 1'b1;
            if (blk_start)              scr_d[l] = 1'b0;
            else if (cnt_q >= CNT_TAIL) scr_d[l] = TS_TAIL_SCR;
            else                        scr_d[l] = 1'b1;
          end
          ST_EIEOS: begin
            adv_d[l] = 1'b1;
            lane_ok  = lane_ok & (lane_sym == (cnt_q[0] ? EIE_ODD : EIE_EVEN));
            // Reseed only after a fully well-formed EIEOS.
            rst_d[l] = last_sym & lane_ok;
          end
          ST_OS_OTHER: adv_d[l] = 1'b1;
          default: ;
        endcase
        state_d[l]    = last_sym ? ST_IDLE : lane_cls;
        eieos_ok_d[l] = lane_ok;
      end else begin
        if (bus.is_k[l]) begin
          if (lane_sym == K_COM) begin
            rst_d[l] = 1'b1;
            adv_d[l] = 1'b1;
            com_d[l] = 1'b1;
          end else begin
            adv_d[l] = (lane_sym != K_SKP);
            ts_d[l]  = ts_q[l];
          end
        end else begin
          // A TS identifier right after COM marks the rest of the set unscrambled.
          lane_ts  = ts_q[l] | (com_q[l] & (lane_sym == D_TS1_ID || lane_sym == D_TS2_ID));
          scr_d[l] = ~lane_ts;
          adv_d[l] = 1'b1;
          ts_d[l]  = lane_ts;
        end
      end
    end
  end

  // Block tracking state: counter, mode latch, lane FSMs and per-lane flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      gen3_q     <= 1'b0;
      state_q    <= '0;
      eieos_ok_q <= '0;
      ts_q       <= '0;
      com_q      <= '0;
    end else if (accept) begin
      cnt_q      <= cnt_d;
      gen3_q     <= gen3_eff;
      state_q    <= state_d;
      eieos_ok_q <= eieos_ok_d;
      ts_q       <= ts_d;
      com_q      <= com_d;
    end
  end

  // Output stage: one cycle behind the accepted symbol; a stall holds all but advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_o_q  <= '0;
      valid_o_q <= 1'b0;
      count_o_q <= '0;
      rst_o_q   <= '0;
      scr_o_q   <= '0;
      adv_o_q   <= '0;
    end else if (accept) begin
      data_o_q  <= bus.sym_data;
      valid_o_q <= 1'b1;
      count_o_q <= cnt_q;
      rst_o_q   <= rst_d;
      scr_o_q   <= scr_d;
      adv_o_q   <= adv_d;
    end else begin
      adv_o_q <= '0;
      if (!bus.back_pressure) valid_o_q <= 1'b0;
    end
  end

  assign bus.sym_data_o     = data_o_q;
  assign bus.sym_valid_o    = valid_o_q;
  assign bus.sym_count_o    = count_o_q;
  assign bus.lfsr_rst       = rst_o_q;
  assign bus.scr_en         = scr_o_q;
  assign bus.advance        = adv_o_q;
  assign bus.lane_state_dbg = state_q;
endmodule

// File: tb/tb_scrambler_ctrl_mlane.sv
// Testbench for scrambler_ctrl_mlane: randomized Gen3 blocks and Gen1 symbol
// streams with stalls, bubbles and resets, checked by a scoreboard against a
// rule-level reference model. Honours SCR_TS_TAIL_SCRAMBLE_EN like the design.
module tb_scrambler_ctrl_mlane;
  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int W     = 1 + LANES*DW + CW + 3*LANES;

`ifdef SCR_TS_TAIL_SCRAMBLE_EN
  localparam bit TAIL_SCR = 1'b1;
`else
  localparam bit TAIL_SCR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scrambler_ctrl_mlane_if #(.LANES(LANES), .DATA_WIDTH(DW), .SYM_CNT_W(CW)) sif ();

  scrambler_ctrl_mlane #(.LANES(LANES), .DATA_WIDTH(DW), .SYM_CNT_W(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (sif)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;
  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  int              blk_pos = 0;
  bit              mode_m  = 1'b0;
  logic [7:0]      blk_hist [LANES][16];
  bit              blk_sync [LANES];
  int              com_len  [LANES];
  bit              second_k [LANES];
  logic [7:0]      second_d [LANES];
  int              ty [LANES];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    blk_pos = 0;
    mode_m  = 1'b0;
    for (int l = 0; l < LANES; l++) com_len[l] = 0;
  endtask

  // Expected response for one accepted symbol slice, from the protocol rules.
  task automatic model_accept(input bit g3, input logic [LANES-1:0] sh,
                              input logic [LANES-1:0] k, input logic [LANES*DW-1:0] d);
    logic [LANES-1:0] e_rst, e_scr, e_adv;
    logic [7:0] sym;
    int pos;
    bit ok, in_ts;
    e_rst = '0; e_scr = '0; e_adv = '0;
    if (blk_pos == 0) mode_m = g3;
    pos = mode_m ? blk_pos : 0;
    for (int l = 0; l < LANES; l++) begin
      sym = d[l*DW +: DW];
      if (mode_m) begin
        com_len[l] = 0;
        if (pos == 0) blk_sync[l] = sh[l];
        blk_hist[l][pos] = sym;
        if (!blk_sync[l]) begin
          e_scr[l] = 1'b1; e_adv[l] = 1'b1;
        end else begin
          case (blk_hist[l][0])
            8'h1E, 8'h2D: begin
              e_adv[l] = 1'b1;
              e_scr[l] = (pos == 0) ? 1'b0 : (pos >= 14 ? TAIL_SCR : 1'b1);
            end
            8'h00: begin
              e_adv[l] = 1'b1;
              if (pos == 15) begin
                ok = 1'b1;
                for (int i = 0; i < 16; i++)
                  if (blk_hist[l][i] != ((i % 2 == 1) ? 8'hFF : 8'h00)) ok = 1'b0;
                e_rst[l] = ok;
              end
            end
            8'hAA: ;
            default: e_adv[l] = 1'b1;
          endcase
        end
      end else begin
        if (k[l]) begin
          if (sym == 8'hBC) begin
            e_rst[l] = 1'b1; e_adv[l] = 1'b1; com_len[l] = 1;
          end else begin
            e_adv[l] = (sym != 8'h1C);
            if (com_len[l] == 1) begin com_len[l] = 2; second_k[l] = 1'b1; second_d[l] = sym; end
          end
        end else begin
          if (com_len[l] == 1) begin com_len[l] = 2; second_k[l] = 1'b0; second_d[l] = sym; end
          in_ts = (com_len[l] == 2) && !second_k[l] && (second_d[l] == 8'h4A || second_d[l] == 8'h45);
          e_scr[l] = !in_ts; e_adv[l] = 1'b1;
        end
      end
    end
    exp_q.push_back({1'b1, d, CW'(pos), e_rst, e_scr, e_adv});
    if (mode_m) blk_pos = (blk_pos + 1) % 16;
  endtask

  function automatic logic [LANES*DW-1:0] rand_data();
    logic [LANES*DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = DW'($urandom_range(0, 255));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit g3, input bit v, input bit bp, input logic [LANES-1:0] sh,
                       input logic [LANES-1:0] k, input logic [LANES*DW-1:0] d);
    @(posedge clk); #1;
    rst               = 1'b0;
    sif.gen3_mode     = g3;
    sif.sym_valid     = v;
    sif.back_pressure = bp;
    sif.sync_header   = sh;
    sif.is_k          = k;
    sif.sym_data      = d;
    if (v && !bp) model_accept(g3, sh, k, d);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst               = 1'b1;
    sif.gen3_mode     = 1'($urandom_range(0, 1));
    sif.sym_valid     = 1'($urandom_range(0, 1));
    sif.back_pressure = 1'($urandom_range(0, 1));
    sif.sync_header   = LANES'($urandom_range(0, 15));
    sif.is_k          = LANES'($urandom_range(0, 15));
    sif.sym_data      = rand_data();
    model_reset();
  endtask

  // A cycle that never transfers a symbol: either a stall or an idle bubble.
  task automatic noise_cycle();
    bit bp, v;
    bp = 1'($urandom_range(0, 1));
    v  = bp ? 1'($urandom_range(0, 1)) : 1'b0;
    drive(1'($urandom_range(0, 1)), v, bp, LANES'($urandom_range(0, 15)),
          LANES'($urandom_range(0, 15)), rand_data());
  endtask

  // types per lane: 0 data, 1 TS1, 2 TS2, 3 EIEOS, 4 bad EIEOS, 5 SKP, 6 other OS, -1 random
  task automatic gen3_block(input int types [LANES], input int cpos, input int stall_at,
                            input int rst_at, input int noise_pct);
    logic [7:0] syms [LANES][16];
    logic [LANES-1:0] sh;
    logic [LANES*DW-1:0] d;
    int t, c;
    bit g3;
    for (int l = 0; l < LANES; l++) begin
      t = (types[l] < 0) ? $urandom_range(0, 6) : types[l];
      c = (cpos < 0) ? $urandom_range(1, 15) : cpos;
      sh[l] = (t != 0);
      for (int p = 0; p < 16; p++) syms[l][p] = 8'($urandom_range(0, 255));
      case (t)
        1: syms[l][0] = 8'h1E;
        2: syms[l][0] = 8'h2D;
        3, 4: begin
          for (int p = 0; p < 16; p++) syms[l][p] = (p % 2 == 1) ? 8'hFF : 8'h00;
          if (t == 4) syms[l][c] = ~syms[l][c];
        end
        5: for (int p = 0; p < 16; p++) syms[l][p] = 8'hAA;
        6: while (syms[l][0] == 8'h1E || syms[l][0] == 8'h2D || syms[l][0] == 8'h00 ||
                  syms[l][0] == 8'hAA) syms[l][0] = 8'($urandom_range(0, 255));
        default: ;
      endcase
    end
    for (int p = 0; p < 16; p++) begin
      if (p == rst_at) begin
        do_reset();
        return;
      end
      for (int l = 0; l < LANES; l++) d[l*DW +: DW] = syms[l][p];
      if (p == stall_at) repeat (3) drive(1'b1, 1'b1, 1'b1, sh, '0, d);
      while ($urandom_range(0, 99) < noise_pct) noise_cycle();
      g3 = (p == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
      drive(g3, 1'b1, 1'b0, sh, LANES'($urandom_range(0, 15)), d);
    end
  endtask

  task automatic gen1_stream(input int n, input int noise_pct);
    logic [LANES-1:0] k;
    logic [LANES*DW-1:0] d;
    int r;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < noise_pct) noise_cycle();
      for (int l = 0; l < LANES; l++) begin
        r = $urandom_range(0, 99);
        if (r < 15)      begin k[l] = 1'b1; d[l*DW +: DW] = 8'hBC; end
        else if (r < 22) begin k[l] = 1'b1; d[l*DW +: DW] = 8'h1C; end
        else if (r < 30) begin
          k[l] = 1'b1;
          case ($urandom_range(0, 3))
            0: d[l*DW +: DW] = 8'hF7;
            1: d[l*DW +: DW] = 8'hFB;
            2: d[l*DW +: DW] = 8'hFE;
            default: d[l*DW +: DW] = 8'h7C;
          endcase
        end
        else if (r < 50) begin k[l] = 1'b0; d[l*DW +: DW] = (r < 40) ? 8'h4A : 8'h45; end
        else             begin k[l] = 1'b0; d[l*DW +: DW] = 8'($urandom_range(0, 255)); end
      end
      drive(1'b0, 1'b1, 1'b0, LANES'($urandom_range(0, 15)), k, d);
    end
  endtask

  // ---------------- monitor ----------------
  bit s_rst = 1'b1;
  bit s_acc = 1'b0;
  bit s_bp  = 1'b0;

  always @(posedge clk) begin
    s_rst <= rst;
    s_acc <= sif.sym_valid && !sif.back_pressure;
    s_bp  <= sif.back_pressure;
  end

  always @(negedge clk) begin
    logic [W-1:0] got, e;
    got = {sif.sym_valid_o, sif.sym_data_o, sif.sym_count_o, sif.lfsr_rst, sif.scr_en, sif.advance};
    if (s_rst) begin
      last_exp = '0;
      chk("reset_zero", got, '0);
    end else if (s_acc) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got=%h exp=none", got);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        chk("sym_out", got, e);
      end
    end else begin
      last_exp[LANES-1:0] = '0;
      if (!s_bp) last_exp[W-1] = 1'b0;
      chk(s_bp ? "stall_hold" : "bubble_hold", got, last_exp);
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    sif.gen3_mode     = 1'b0;
    sif.sym_valid     = 1'b0;
    sif.back_pressure = 1'b0;
    sif.sync_header   = '0;
    sif.is_k          = '0;
    sif.sym_data      = '0;
    model_reset();
    repeat (3) do_reset();

    ty = '{0, 0, 0, 0};  gen3_block(ty, -1, -1, -1, 0);   // all data lanes
    ty = '{1, 2, 1, 2};  gen3_block(ty, -1, -1, -1, 0);   // TS1/TS2
    ty = '{3, 4, 3, 3};  gen3_block(ty, 7, -1, -1, 0);    // EIEOS, lane1 bad at sym7
    ty = '{0, 5, 6, 5};  gen3_block(ty, -1, -1, -1, 0);   // data / SKP / other OS
    ty = '{-1, -1, -1, -1};
    gen3_block(ty, -1, 5, -1, 0);                         // 3-cycle stall at sym5
    repeat (20) gen3_block(ty, -1, -1, -1, 10);

    // Gen1 directed: COM, TS1 id, D, SKP, D, COM, D on every lane
    drive(1'b0, 1'b1, 1'b0, '0, {LANES{1'b1}}, {LANES{8'hBC}});
    drive(1'b0, 1'b1, 1'b0, '0, {LANES{1'b0}}, {LANES{8'h4A}});
    drive(1'b0, 1'b1, 1'b0, '0, {LANES{1'b0}}, {LANES{8'h10}});
    drive(1'b0, 1'b1, 1'b0, '0, {LANES{1'b1}}, {LANES{8'h1C}});
    drive(1'b0, 1'b1, 1'b0, '0, {LANES{1'b0}}, {LANES{8'h33}});
    drive(1'b0, 1'b1, 1'b0, '0, {LANES{1'b1}}, {LANES{8'hBC}});
    drive(1'b0, 1'b1, 1'b0, '0, {LANES{1'b0}}, {LANES{8'h33}});
    gen1_stream(200, 10);
    do_reset();                                           // reset inside Gen1 traffic
    gen1_stream(20, 0);

    gen3_block(ty, -1, -1, 9, 0);                         // reset mid-block
    repeat (10) gen3_block(ty, -1, -1, -1, 15);
    gen1_stream(100, 15);

    repeat (4) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("queue_empty", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
